// File: rtl/apb_master.sv
// APB requester: valid/ready command port to APB SETUP/ACCESS transfers,
// with a one-cycle response pulse and an optional ACCESS timeout.
module apb_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_write,
    input  logic [31:0] i_cmd_addr,
    input  logic [31:0] i_cmd_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_rsp_timeout,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic        PSELx,
    output logic        PENABLE,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_e;

    localparam int CW = (TIMEOUT_CYCLES > 0) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   paddr_q, paddr_d;
    logic          pwrite_q, pwrite_d;
    logic [31:0]   pwdata_q, pwdata_d;
    logic          psel_q, psel_d;
    logic          penable_q, penable_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rsp_to_q, rsp_to_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
        unique case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    paddr_d  = i_cmd_addr;
                    pwrite_d = i_cmd_write;
                    pwdata_d = i_cmd_wdata;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PSLVERR;
                    rsp_to_d    = 1'b0;
                    if (!pwrite_q) begin
                        rsp_rdata_d = PRDATA;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    // Abort on the last permitted ACCESS cycle
                    if (TO_EN && cnt_q == LAST) begin
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_to_d    = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    assign o_cmd_ready   = (state_q == IDLE) && !i_reset;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rdata   = rsp_rdata_q;
    assign o_rsp_err     = rsp_err_q;
    assign o_rsp_timeout = rsp_to_q;
    assign PADDR         = paddr_q;
    assign PWRITE        = pwrite_q;
    assign PWDATA        = pwdata_q;
    assign PSELx         = psel_q;
    assign PENABLE       = penable_q;

endmodule

// File: tb/tb_apb_master.sv
// Randomized scoreboard bench for apb_master with a behavioural slave
// and a cycle-exact transaction model.
module tb_apb_master;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_write;
    logic [31:0] i_cmd_addr;
    logic [31:0] i_cmd_wdata;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_rsp_timeout;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PSELx;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    apb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk),
        .i_reset(i_reset),
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(o_cmd_ready),
        .i_cmd_write(i_cmd_write),
        .i_cmd_addr(i_cmd_addr),
        .i_cmd_wdata(i_cmd_wdata),
        .o_rsp_valid(o_rsp_valid),
        .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_err(o_rsp_err),
        .o_rsp_timeout(o_rsp_timeout),
        .PADDR(PADDR),
        .PWRITE(PWRITE),
        .PWDATA(PWDATA),
        .PSELx(PSELx),
        .PENABLE(PENABLE),
        .PRDATA(PRDATA),
        .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned acc;
        int unsigned rsp;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    exp_t q[$];
    int unsigned cyc = 0;
    int errors = 0;
    int checks = 0;

    logic [31:0] model_rd;
    int          cur_w;
    logic        cur_err;
    logic [31:0] cur_rd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h",
                     name, cyc, act, exp);
        end
    endtask

    // Slave: ready after cur_w wait states, random noise outside ACCESS
    initial begin
        int acc_cnt;
        logic rdy;
        acc_cnt = 0;
        PREADY = 1'b0;
        PSLVERR = 1'b0;
        PRDATA = '0;
        forever begin
            @(negedge clk);
            if (PSELx && PENABLE) begin
                rdy = (acc_cnt == cur_w);
                PREADY = rdy;
                PSLVERR = rdy ? cur_err : 1'($urandom);
                PRDATA = rdy ? cur_rd : $urandom;
                acc_cnt++;
            end else begin
                acc_cnt = 0;
                PREADY = 1'($urandom);
                PSLVERR = 1'($urandom);
                PRDATA = $urandom;
            end
        end
    end

    logic [31:0] hold_addr, hold_wd, hold_rd;
    logic        hold_wr;

    task automatic mon();
        logic exp_sel, exp_en;
        if (i_reset) begin
            hold_addr = '0;
            hold_wd = '0;
            hold_wr = 1'b0;
            hold_rd = '0;
            chk("rst_psel", PSELx, 0);
            chk("rst_penable", PENABLE, 0);
            chk("rst_paddr", PADDR, 0);
            chk("rst_pwrite", PWRITE, 0);
            chk("rst_pwdata", PWDATA, 0);
            chk("rst_rsp_valid", o_rsp_valid, 0);
            chk("rst_rdata", o_rsp_rdata, 0);
            chk("rst_err", o_rsp_err, 0);
            chk("rst_timeout", o_rsp_timeout, 0);
            chk("rst_cmd_ready", o_cmd_ready, 0);
            return;
        end
        exp_sel = 1'b0;
        exp_en = 1'b0;
        if (q.size() > 0 && cyc >= q[0].acc && cyc < q[0].rsp) begin
            exp_sel = 1'b1;
            exp_en = (cyc > q[0].acc);
            hold_addr = q[0].addr;
            hold_wd = q[0].wd;
            hold_wr = q[0].wr;
        end
        chk("psel", PSELx, exp_sel);
        chk("penable", PENABLE, exp_en);
        chk("cmd_ready", o_cmd_ready, !exp_sel);
        chk("paddr", PADDR, hold_addr);
        chk("pwrite", PWRITE, hold_wr);
        chk("pwdata", PWDATA, hold_wd);
        if (q.size() > 0 && cyc == q[0].rsp) begin
            chk("rsp_valid", o_rsp_valid, 1);
            chk("rsp_err", o_rsp_err, q[0].err);
            chk("rsp_timeout", o_rsp_timeout, q[0].to);
            hold_rd = q[0].rdata;
            void'(q.pop_front());
        end else begin
            chk("rsp_valid_idle", o_rsp_valid, 0);
        end
        chk("rsp_rdata", o_rsp_rdata, hold_rd);
    endtask

    initial begin
        hold_addr = '0;
        hold_wd = '0;
        hold_wr = 1'b0;
        hold_rd = '0;
        forever begin
            @(posedge clk);
            #1;
            mon();
        end
    end

    task automatic issue(input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input int w,
                         input logic err, input logic [31:0] rd);
        exp_t e;
        int guard;
        @(negedge clk);
        i_cmd_valid = 1'b1;
        i_cmd_write = wr;
        i_cmd_addr = addr;
        i_cmd_wdata = wd;
        guard = 0;
        while (!o_cmd_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_wait: got no ready expected ready");
                i_cmd_valid = 1'b0;
                return;
            end
        end
        cur_w = w;
        cur_err = err;
        cur_rd = rd;
        e.acc = cyc + 1;
        e.wr = wr;
        e.addr = addr;
        e.wd = wd;
        if (w < TO) begin
            e.rsp = e.acc + 2 + w;
            e.err = err;
            e.to = 1'b0;
            if (!wr) model_rd = rd;
        end else begin
            e.rsp = e.acc + 1 + TO;
            e.err = 1'b1;
            e.to = 1'b1;
        end
        e.rdata = model_rd;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_cmd_valid = 1'b0;
            i_cmd_write = 1'($urandom);
            i_cmd_addr = $urandom;
            i_cmd_wdata = $urandom;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        i_reset = 1'b1;
        i_cmd_valid = 1'b0;
        q.delete();
        model_rd = '0;
        repeat (n - 1) @(negedge clk);
        @(negedge clk);
        i_reset = 1'b0;
    endtask

    initial begin
        int guard;
        i_reset = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_write = 1'b0;
        i_cmd_addr = '0;
        i_cmd_wdata = '0;
        model_rd = '0;
        cur_w = 0;
        cur_err = 1'b0;
        cur_rd = '0;
        repeat (3) @(negedge clk);
        i_reset = 1'b0;

        issue(1'b0, 32'h3, 32'h0, 0, 1'b0, 32'hDEADBEEF);
        idle(4);
        issue(1'b1, 32'h5, 32'h12345678, 3, 1'b0, 32'h0BADF00D);
        idle(4);
        issue(1'b0, 32'h100, 32'h0, 0, 1'b1, 32'hCAFEF00D);
        idle(4);
        issue(1'b0, 32'h20, 32'h0, 1000, 1'b0, 32'h11111111);
        idle(8);
        issue(1'b0, 32'hA0, 32'h0, 0, 1'b0, 32'hA0A0A0A0);
        issue(1'b1, 32'hA4, 32'h55AA55AA, 0, 1'b0, 32'h0);
        issue(1'b0, 32'hA8, 32'h0, 0, 1'b0, 32'hA8A8A8A8);
        idle(5);
        issue(1'b0, 32'h44, 32'h0, 5, 1'b0, 32'h44444444);
        repeat (3) @(negedge clk);
        do_reset(2);
        idle(3);

        for (int i = 0; i < 150; i++) begin
            issue(1'($urandom), $urandom, $urandom,
                  int'($urandom_range(0, 6)), 1'($urandom), $urandom);
            idle(int'($urandom_range(0, 3)));
        end

        guard = 0;
        while (q.size() > 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
